// File: rtl/instr_issue_queue.sv
// Show-ahead circular issue queue between the dispatcher and one execution unit.
// Entries leave in order, and only when the consumer requests a dequeue and the unit is ready.
// full, empty and count are decoded from a registered occupancy counter,
// so they never depend on comparing the two pointers.
module instr_issue_queue #(
  parameter int DATA_WIDTH = 55,
  parameter int DEPTH      = 8,
  // Derived from DEPTH. Callers must not override it.
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enq,
  input  logic                  deq,
  input  logic                  ready_i,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_W:0]        count,
  output logic                  issue_o
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  do_enq;
  logic                  do_deq;

  // Decode the status flags and the accepted operations from the registered count.
  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    full    = 1'b0;
    empty   = 1'b0;
    do_enq  = 1'b0;
    do_deq  = 1'b0;
    if (count == DEPTH_CNT) full  = 1'b1;
    if (count == '0)        empty = 1'b1;
    // When the queue is full, a simultaneous enqueue is dropped. There is no write-through.
    do_enq  = enq & ~full;
    // When the queue is empty, a simultaneous dequeue is ignored. There is no bypass.
    do_deq  = deq & ready_i & ~empty;
  end

  assign issue_o = do_deq;

  // Show the head entry with zero latency after a pointer update. Show zeros while empty.
  always_comb begin
    data_out = '0;
    if (!empty) data_out = mem[rd_ptr];
  end

  // Update the pointers and the occupancy. An asynchronous reset discards every entry at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments, so every flop in this block samples pre-edge values.
      // The pointers are a power of two wide, so they wrap to zero on their own.
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Write into the storage array on each accepted enqueue.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset. Occupancy, not contents, defines validity, and this lets it map to RAM.
    if (do_enq) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Self-checking bench for instr_issue_queue.
// A queue-based model of the FIFO is checked against the DUT on every falling clock edge.
// Directed scenarios add literal expectations, and a randomized phase follows them.
module tb_instr_issue_queue;

  localparam int DW    = 55;
  localparam int DEPTH = 8;
  localparam int PW    = $clog2(DEPTH);

  logic          clk;
  logic          resetn;
  logic          enq;
  logic          deq;
  logic          ready_i;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
  logic [PW:0]   count;
  logic          issue_o;

  int n_checks = 0;
  int n_fail   = 0;

  // The model's queue contents, oldest entry at index 0.
  logic [DW-1:0] model_q[$];

  instr_issue_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .enq      (enq),
    .deq      (deq),
    .ready_i  (ready_i),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .issue_o  (issue_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update. The async reset empties the queue. On each edge, apply the FIFO rules to the pre-edge size.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      model_q.delete();
    end else begin
      automatic int  sz = model_q.size();
      automatic bit  a_enq = enq && (sz < DEPTH);
      automatic bit  a_deq = deq && ready_i && (sz > 0);
      if (a_deq) void'(model_q.pop_front());
      if (a_enq) model_q.push_back(data_in);
    end
  end

  // Compare process. Check every DUT output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      begin
        automatic int            sz = model_q.size();
        automatic logic [DW-1:0] exp_head = (sz > 0) ? model_q[0] : '0;
        check("count",    64'(count),    64'(sz));
        check("empty",    64'(empty),    64'(sz == 0));
        check("full",     64'(full),     64'(sz == DEPTH));
        check("data_out", 64'(data_out), 64'(exp_head));
        check("issue_o",  64'(issue_o),  64'(deq && ready_i && (sz > 0)));
      end
    end
  end

  // Apply one cycle of inputs, 1 ns after the rising edge.
  task automatic drive(input bit e, input bit d, input bit r, input logic [DW-1:0] din);
    @(posedge clk);
    #1;
    enq     = e;
    deq     = d;
    ready_i = r;
    data_in = din;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  // Hold the current inputs for 1 ns so the combinational outputs settle before the literal checks.
  task automatic settle();
    #1;
  endtask

  initial begin
    resetn  = 1'b0;
    enq     = 1'b0;
    deq     = 1'b0;
    ready_i = 1'b0;
    data_in = '0;

    // Check the reset state.
    #3;
    check("rst_empty",   64'(empty),    64'd1);
    check("rst_full",    64'(full),     64'd0);
    check("rst_count",   64'(count),    64'd0);
    check("rst_dataout", 64'(data_out), 64'd0);
    check("rst_issue",   64'(issue_o),  64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // A dequeue while empty is ignored.
    drive(1'b0, 1'b1, 1'b1, '0);
    settle();
    check("deq_empty_issue", 64'(issue_o), 64'd0);
    idle();
    settle();
    check("deq_empty_count", 64'(count), 64'd0);

    // Fill the queue with 1..8. The 9th enqueue is dropped.
    for (int i = 1; i <= DEPTH; i++) drive(1'b1, 1'b0, 1'b0, DW'(i));
    drive(1'b1, 1'b0, 1'b0, DW'(9));
    settle();
    check("fill_full",  64'(full),  64'd1);
    check("fill_count", 64'(count), 64'd8);
    for (int k = 1; k <= DEPTH; k++) begin
      drive(1'b0, 1'b1, 1'b1, '0);
      settle();
      check("drain_seq", 64'(data_out), 64'(k));
    end
    idle();
    settle();
    check("drain_empty", 64'(empty), 64'd1);

    // With ready_i low, the dequeue is held off.
    drive(1'b1, 1'b0, 1'b0, DW'('hAA));
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, '0);
      settle();
      check("nready_issue", 64'(issue_o),  64'd0);
      check("nready_count", 64'(count),    64'd1);
      check("nready_data",  64'(data_out), 64'h0AA);
    end
    drive(1'b0, 1'b1, 1'b1, '0);
    settle();
    check("ready_issue", 64'(issue_o), 64'd1);
    idle();
    settle();
    check("ready_empty", 64'(empty), 64'd1);

    // On a full queue, enq+deq pops the head and drops the enqueue.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 1'b0, DW'('h20 + i));
    drive(1'b1, 1'b1, 1'b1, DW'('h55));
    idle();
    settle();
    check("fullboth_count", 64'(count),    64'd7);
    check("fullboth_head",  64'(data_out), 64'h21);
    for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, 1'b1, 1'b1, '0);
    idle();
    settle();
    check("fullboth_empty", 64'(empty), 64'd1);

    // At count 3, enq+deq keeps the count and preserves order.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, DW'('h30 + i));
    drive(1'b1, 1'b1, 1'b1, DW'('h33));
    idle();
    settle();
    check("mid_count", 64'(count),    64'd3);
    check("mid_head",  64'(data_out), 64'h31);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, '0);

    // Wrap-around: 5 in, 5 out, then 8 in.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, DW'('h40 + i));
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, '0);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 1'b0, DW'('h10 + i));
    idle();
    settle();
    check("wrap_full", 64'(full), 64'd1);
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b0, 1'b1, 1'b1, '0);
      settle();
      check("wrap_seq", 64'(data_out), 64'('h10 + k));
    end

    // An asynchronous reset in mid-cycle with 4 entries queued.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, DW'('h60 + i));
    idle();
    #1 resetn = 1'b0;
    #1;
    check("async_count", 64'(count), 64'd0);
    check("async_empty", 64'(empty), 64'd1);
    @(posedge clk);
    #1 resetn = 1'b1;
    drive(1'b1, 1'b0, 1'b0, DW'('h3C));
    idle();
    settle();
    check("post_rst_head", 64'(data_out), 64'h3C);

    // Randomized phase. The compare process does the checking.
    for (int c = 0; c < 3000; c++) begin
      automatic logic [DW-1:0] rd = DW'({$urandom(), $urandom()});
      drive(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
            ($urandom_range(0, 99) < 70), rd);
    end
    idle();
    @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
